// File: rtl/pll_reset_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encodings and sizing helpers.
// The state encodings are also decoded by the PLL wrapper and the debug mux.
package pll_reset_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// Control/status bundle between the PLL reset sequencer and its environment.
interface pll_reset_ctrl_if;

    logic                                 enable;
    logic                                 pll_lock;
    logic                                 pll_resetb;
    logic                                 pll_ready;
    logic                                 fault;
    logic [3:0]                           retry_cnt;
    logic [7:0]                           loss_cnt;
    logic [pll_reset_ctrl_pkg::STATE_W-1:0] state_dbg;

    modport master (
        output enable, pll_lock,
        input  pll_resetb, pll_ready, fault, retry_cnt, loss_cnt, state_dbg
    );

    modport slave (
        input  enable, pll_lock,
        output pll_resetb, pll_ready, fault, retry_cnt, loss_cnt, state_dbg
    );

endinterface

// File: rtl/pll_reset_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
module pll_reset_ctrl_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: timed reset hold, lock wait with timeout and retry, lock qualification.
//   state     | meaning
//   IDLE      | disabled, PLL held in reset
//   HOLD      | PLL held in reset for RESET_CYCLES
//   WAIT_LOCK | reset released, waiting up to LOCK_TIMEOUT for lock
//   STABLE    | lock seen, qualifying for LOCK_STABLE consecutive cycles
//   RUN       | lock qualified, pll_ready high
//   FAULT     | MAX_RETRY consecutive timeouts, sticky until enable drops
module pll_reset_ctrl
    import pll_reset_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    pll_reset_ctrl_if.slave  pll_if
);

    localparam int CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    pll_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [3:0]    retry_inc;
    logic [7:0]    loss_q, loss_d;
    logic          resetb_q, resetb_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    logic          lock_s;

    pll_reset_ctrl_sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_if.pll_lock),
        .q_o   (lock_s)
    );

    assign retry_inc = retry_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= 4'd0;
            loss_q   <= 8'd0;
            resetb_q <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            resetb_q <= resetb_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pll_if.enable) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable wins over any transition decided above.
        if (!pll_if.enable) begin
            state_d = ST_IDLE;
            retry_d = 4'd0;
        end

        cnt_d = '0;
        if ((state_d == state_q) &&
            ((state_q == ST_HOLD) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE))) begin
            cnt_d = cnt_q + CW'(1);
        end

        resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
        ready_d  = (state_d == ST_RUN);
        fault_d  = (state_d == ST_FAULT);
    end

    assign pll_if.pll_resetb = resetb_q;
    assign pll_if.pll_ready  = ready_q;
    assign pll_if.fault      = fault_q;
    assign pll_if.retry_cnt  = retry_q;
    assign pll_if.loss_cnt   = loss_q;
    assign pll_if.state_dbg  = state_q;

endmodule
